// File: rtl/change_dispenser.sv
// Coin-return controller: pays a latched amount through three hoppers, largest coin first,
// with a per-coin request/acknowledge handshake and a timeout that ends the job as a fault.
module change_dispenser #(
    parameter int unsigned COIN_HI     = 50,
    parameter int unsigned COIN_MID    = 10,
    parameter int unsigned COIN_LO     = 5,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] amount,
    input  logic        abort,
    input  logic [2:0]  empty,
    input  logic [2:0]  eject_ack,
    output logic [2:0]  eject_req,
    output logic        busy,
    output logic        done,
    output logic        short,
    output logic        fault,
    output logic [11:0] remaining,
    output logic [5:0]  cnt_hi,
    output logic [5:0]  cnt_mid,
    output logic [5:0]  cnt_lo
);

    localparam logic [11:0] VAL_HI  = 12'(COIN_HI);
    localparam logic [11:0] VAL_MID = 12'(COIN_MID);
    localparam logic [11:0] VAL_LO  = 12'(COIN_LO);
    localparam logic [15:0] TMO     = 16'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SELECT, REQ, REL, DONE, FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] remaining_q, remaining_d;
    logic [5:0]  cnt_hi_q, cnt_hi_d, cnt_mid_q, cnt_mid_d, cnt_lo_q, cnt_lo_d;
    logic [2:0]  eject_req_q, eject_req_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] timer_q, timer_d;
    logic        short_q, short_d, fault_q, fault_d;

    logic [2:0]  eligible;
    logic [15:0] timer_inc;
    logic        ack_sel;
    logic [11:0] sel_val;

    always_comb begin
        eligible[2] = (remaining_q >= VAL_HI)  && !empty[2];
        eligible[1] = (remaining_q >= VAL_MID) && !empty[1];
        eligible[0] = (remaining_q >= VAL_LO)  && !empty[0];
        timer_inc   = timer_q + 16'd1;
        ack_sel     = eject_ack[sel_q];
        case (sel_q)
            2'd2:    sel_val = VAL_HI;
            2'd1:    sel_val = VAL_MID;
            default: sel_val = VAL_LO;
        endcase
    end

    // NOTE: every variable gets its hold value before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_hi_d    = cnt_hi_q;
        cnt_mid_d   = cnt_mid_q;
        cnt_lo_d    = cnt_lo_q;
        eject_req_d = eject_req_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        short_d     = short_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    cnt_hi_d    = '0;
                    cnt_mid_d   = '0;
                    cnt_lo_d    = '0;
                    short_d     = 1'b0;
                    fault_d     = 1'b0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (abort || remaining_q == '0 || eligible == 3'b000) begin
                    short_d = (remaining_q != '0);
                    state_d = DONE;
                end else begin
                    if (eligible[2])      sel_d = 2'd2;
                    else if (eligible[1]) sel_d = 2'd1;
                    else                  sel_d = 2'd0;
                    eject_req_d = eligible[2] ? 3'b100 : (eligible[1] ? 3'b010 : 3'b001);
                    timer_d     = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (ack_sel) begin
                    remaining_d = remaining_q - sel_val;
                    case (sel_q)
                        2'd2:    cnt_hi_d  = (cnt_hi_q  == 6'd63) ? cnt_hi_q  : cnt_hi_q  + 6'd1;
                        2'd1:    cnt_mid_d = (cnt_mid_q == 6'd63) ? cnt_mid_q : cnt_mid_q + 6'd1;
                        default: cnt_lo_d  = (cnt_lo_q  == 6'd63) ? cnt_lo_q  : cnt_lo_q  + 6'd1;
                    endcase
                    eject_req_d = '0;
                    timer_d     = '0;
                    state_d     = REL;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO) begin
                        eject_req_d = '0;
                        fault_d     = 1'b1;
                        state_d     = FAULT;
                    end
                end
            end
            REL: begin
                if (!ack_sel) begin
                    state_d = SELECT;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cnt_hi_q    <= '0;
            cnt_mid_q   <= '0;
            cnt_lo_q    <= '0;
            eject_req_q <= '0;
            sel_q       <= '0;
            timer_q     <= '0;
            short_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_hi_q    <= cnt_hi_d;
            cnt_mid_q   <= cnt_mid_d;
            cnt_lo_q    <= cnt_lo_d;
            eject_req_q <= eject_req_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            short_q     <= short_d;
            fault_q     <= fault_d;
        end
    end

    assign eject_req = eject_req_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) || (state_q == FAULT);
    assign short     = short_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;
    assign cnt_hi    = cnt_hi_q;
    assign cnt_mid   = cnt_mid_q;
    assign cnt_lo    = cnt_lo_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Controller for the coin-return path of the vending machine. It pays out a latched refund/change amount through three coin hoppers (5 jiao, 1 yuan, 5 yuan) using a greedy largest-coin-first schedule. It runs a per-coin request/acknowledge handshake with each hopper and reports completion, shortfall and hopper faults. It sits between the top-level purchase state machine, which issues `start` with the current balance on refund, and the hopper driver hardware. All amounts are in jiao: 5, 10 and 50 units.

## Interface
- `COIN_HI`, 50, value of hopper 2 coin (jiao)
- `COIN_MID`, 10, value of hopper 1 coin
- `COIN_LO`, 5, value of hopper 0 coin
- `ACK_TIMEOUT`, 1000, cycles allowed for each handshake phase before fault; 16-bit timer
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to pay `amount`; honoured only in IDLE
- `amount`  in  12  amount to pay, latched on accepted `start`
- `abort`  in  1  level; stop after the coin currently in flight
- `empty`  in  3  hopper-empty flags: [2]=HI, [1]=MID, [0]=LO
- `eject_ack`  in  3  per-hopper acknowledge, same bit order
- `eject_req`  out  3  one-hot eject request, registered
- `busy`  out  1  high from the cycle after accepted `start` until DONE/FAULT exit
- `done`  out  1  one-cycle pulse at end of every job (normal, short, abort, fault)
- `short`  out  1  job ended with `remaining` != 0 and no fault; held until next `start`
- `fault`  out  1  handshake timeout; held until next accepted `start`
- `remaining`  out  12  amount still owed
- `cnt_hi`, `cnt_mid`, `cnt_lo`  out  6 each  coins paid this job, saturating at 63

## Operation
- Reset (`reset`=0): all outputs go to 0 immediately, including `eject_req`. State is IDLE and the timer is 0.
- States: IDLE, SELECT, REQ, REL, DONE, FAULT.
- IDLE + `start`=1: latch `amount` into `remaining`, clear counters, `short` and `fault`, and go to SELECT.
- `start` outside IDLE is ignored.
- SELECT evaluates, in a single cycle:
  - Coin c is eligible if `remaining` >= value(c) and `empty`[c]=0.
  - Priority is HI > MID > LO.
  - If `abort`=1, or `remaining`=0, or no coin is eligible: go to DONE.
  - Otherwise: set the `eject_req` bit of the chosen coin, clear the timer, and go to REQ.
- REQ: hold `eject_req`.
  - On `eject_ack`[sel]=1: subtract value(sel) from `remaining`, increment that counter, clear `eject_req`, clear the timer, and go to REL.
- REL: wait for `eject_ack`[sel]=0, then go to SELECT.
- Acks on bits other than `sel` are ignored in every state.
- Timer runs in REQ and REL. When it reaches `ACK_TIMEOUT`: clear `eject_req`, go to FAULT. `remaining` is not decremented for the coin in flight.
- DONE: pulse `done`. `short` is set if `remaining` != 0. Next state is IDLE.
- FAULT: pulse `done`, set `fault`. `short` stays 0. Next state is IDLE.
- `remaining` cannot underflow, because the eligibility check guarantees it. Amounts that are not a multiple of `COIN_LO` end with `short`=1 and the residue left in `remaining`.
- `empty` and `abort` are sampled only in SELECT. An abort raised during REQ/REL lets the in-flight coin complete.

## Timing
- `start` at cycle 0 → SELECT at cycle 1 (`busy`=1) → `eject_req` high at cycle 2.
- Ack seen at cycle k → `eject_req` low and `remaining` updated at cycle k+1.
- Minimum per-coin cost with a 1-cycle ack pulse is 3 cycles: SELECT, REQ, REL.
- The end-of-job SELECT cycle is followed by DONE. `done` and `busy` drop together: `done`=1 and `busy`=1 in the DONE/FAULT cycle, then `busy`=0 in IDLE.
- Reset mid-job aborts without `done`. Hopper drivers must treat `eject_req` falling as cancel.
- `eject_req` is never more than one-hot and never changes while waiting in REQ.

## Test plan
- `amount`=65, all hoppers full, ack 2 cycles after req → coins 50, 10, 5 in order; `cnt_hi/mid/lo`=1/1/1; `remaining`=0; `short`=0; exactly one `done` pulse.
- `amount`=30, `empty`=3'b010 → six LO coins; `cnt_lo`=6; `remaining`=0; MID hopper never requested.
- `amount`=7 → one LO coin; then `done`, `short`=1, `remaining`=2.
- `ACK_TIMEOUT`=16, `amount`=50, no ack → `eject_req`=3'b100 for 16 cycles, then 0; `fault`=1, `done` pulse, `remaining`=50, `short`=0.
- `amount`=65, `abort` raised during the first REQ → the 50 coin completes, then `done`; `remaining`=15, `short`=1. A `start` pulse during busy is ignored.
- `reset` low during REQ → `eject_req`, `busy` and counters are 0 in the same cycle. After release, IDLE accepts a new `start`.
